// File: rtl/fb_fill_engine_if.sv
// Command channel and framebuffer write port of fb_fill_engine, bundled for the engine (slave) and its host (master).
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready; the host holds cmd_* stable while cmd_valid waits.
interface fb_fill_engine_if #(
    parameter int ADDR_W = 17
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x0;
    logic [9:0]        cmd_x1;
    logic [9:0]        cmd_y0;
    logic [9:0]        cmd_y1;
    logic [11:0]       cmd_color;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_din;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        input  cmd_ready, mem_we, mem_addr, mem_din, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
        output cmd_ready, mem_we, mem_addr, mem_din, busy, done
    );
endinterface

// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: writes one RGB444 pixel per clock into a linear framebuffer,
// row-major over a clipped, inclusive rectangle.
module fb_fill_engine #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic             clk,
    input  logic             rstn,
    fb_fill_engine_if.slave  bus,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [9:0]        X_MAX     = 10'(H_RES - 1);
    localparam logic [9:0]        Y_MAX     = 10'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_RES);
    localparam bit                FAST_BASE = (H_RES == 320);

    state_t            state;
    logic [9:0]        x0_r, x1_r, y0_r, y1_r;
    logic [11:0]       color_r;
    logic [9:0]        x, y;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base_acc;
    logic [9:0]        cnt;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [11:0]       mem_din_r;
    logic              done_r;

    logic [9:0]        x1_c, y1_c;
    logic              empty;
    logic              base_ready;
    logic [ADDR_W-1:0] shift_base, first_base;

    // 320*y = 256*y + 64*y; other widths accumulate H_RES once per SETUP cycle.
    always_comb begin
        x1_c       = (x1_r > X_MAX) ? X_MAX : x1_r;
        y1_c       = (y1_r > Y_MAX) ? Y_MAX : y1_r;
        empty      = (x0_r > x1_c) || (y0_r > y1_c);
        shift_base = (ADDR_W'(y0_r) << 8) + (ADDR_W'(y0_r) << 6);
        base_ready = FAST_BASE || (cnt == y0_r);
        first_base = FAST_BASE ? shift_base : base_acc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            x0_r       <= '0;
            x1_r       <= '0;
            y0_r       <= '0;
            y1_r       <= '0;
            color_r    <= '0;
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            base_acc   <= '0;
            cnt        <= '0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x0_r     <= bus.cmd_x0;
                        x1_r     <= bus.cmd_x1;
                        y0_r     <= bus.cmd_y0;
                        y1_r     <= bus.cmd_y1;
                        color_r  <= bus.cmd_color;
                        base_acc <= '0;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    x1_r <= x1_c;
                    y1_r <= y1_c;
                    if (empty) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else if (base_ready) begin
                        row_base   <= first_base;
                        x          <= x0_r;
                        y          <= y0_r;
                        mem_we_r   <= 1'b1;
                        mem_addr_r <= first_base + ADDR_W'(x0_r);
                        mem_din_r  <= color_r;
                        state      <= FILL;
                    end else begin
                        base_acc <= base_acc + ROW_STEP;
                        cnt      <= cnt + 10'd1;
                    end
                end
                FILL: begin
                    // The pixel on mem_addr now is (x, y); schedule the next one.
                    if (x == x1_r && y == y1_r) begin
                        mem_we_r <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end else if (x == x1_r) begin
                        x          <= x0_r;
                        y          <= y + 10'd1;
                        row_base   <= row_base + ROW_STEP;
                        mem_addr_r <= row_base + ROW_STEP + ADDR_W'(x0_r);
                    end else begin
                        x          <= x + 10'd1;
                        mem_addr_r <= row_base + ADDR_W'(x + 10'd1);
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_din   = mem_din_r;
    assign bus.done      = done_r;
    assign fsm_state     = state;
endmodule
